// File: rtl/lpc_pkg.sv
// ============================================================================
// Module   : lpc_pkg
// Purpose  : Shared types and helpers for the Levinson-Durbin datapath blocks
//            (state encoding, default widths, truncate-toward-zero shift).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpc_pkg;

  // Defaults shared by every Levinson block so they agree on Q-format.
  localparam int W_DEFAULT     = 32;
  localparam int SHIFT_DEFAULT = 27;

  // Working width of trunc0; callers sign-extend into it and cast back out.
  localparam int TRUNC_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Signed divide by 2^sh rounding toward zero. Negative values are biased by
  // 2^sh-1 before the arithmetic shift, which equals ((x-1)>>>sh)+1 without
  // the risk of wrapping at the most negative input.
  function automatic logic signed [TRUNC_W-1:0] trunc0(
    input logic signed [TRUNC_W-1:0] x,
    input int                        sh
  );
    logic signed [TRUNC_W-1:0] bias;
    bias = '0;
    if (x[TRUNC_W-1]) begin
      bias = (TRUNC_W'(1) <<< sh) - TRUNC_W'(1);
    end
    return (x + bias) >>> sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trunc0_shift.sv
// ============================================================================
// Module   : trunc0_shift
// Purpose  : Combinational signed right shift by SH with truncation toward
//            zero; result resized (sign-extended or truncated) to OUT_W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trunc0_shift
  import lpc_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 64,
  parameter int SH    = 27
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  assign dout = OUT_W'(trunc0(TRUNC_W'(din), SH));

endmodule

`default_nettype wire

// File: rtl/levinson_dot.sv
// ============================================================================
// Module   : levinson_dot
// Purpose  : Sequential fixed-point MAC for the Levinson-Durbin q update.
//            q_out = sat(trunc0((2*q_in + sum trunc0(r*a / 2^SHIFT)) / 2))
//            Pairs arrive over a valid/ready stream; result leaves over a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module levinson_dot
  import lpc_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int SHIFT     = SHIFT_DEFAULT,
  parameter int MAX_ORDER = 16,
  parameter int LEN_W     = $clog2(MAX_ORDER + 1),
  parameter int ACC_W     = 2 * W - SHIFT + $clog2(MAX_ORDER) + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic signed [W-1:0] q_in,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] r_in,
  input  logic signed [W-1:0] a_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] q_out,
  output logic                sat
);

  localparam int                      PW       = 2 * W;
  localparam logic [LEN_W-1:0]        LEN_MAX  = LEN_W'(MAX_ORDER);
  localparam logic signed [ACC_W-1:0] Q_HI     = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_LO     = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  // DRAIN always waits out both pipeline stages, so the output latency is the
  // same whether or not any pair was accumulated (len=0 included).
  localparam logic [1:0]              FLUSH_CY = 2'd2;

  state_t                  state;
  state_t                  state_nx;
  logic [LEN_W-1:0]        remaining;
  logic [LEN_W-1:0]        len_clamped;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W-1:0] half;
  logic signed [PW-1:0]    p;
  logic                    p_valid;
  logic [1:0]              flush;
  logic                    accept;
  logic                    last_pair;
  logic                    drain_done;
  logic                    sat_hi;
  logic                    sat_lo;

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  // in_ready comes from registered state only, never from in_valid.
  assign in_ready    = (state == S_ACCUM) && (remaining != '0);
  assign accept      = in_valid && in_ready;
  assign last_pair   = accept && (remaining == LEN_W'(1));
  assign drain_done  = (flush == 2'd0) && !p_valid;

  // Product scaling into the accumulator's Q-format.
  trunc0_shift #(.IN_W(PW), .OUT_W(ACC_W), .SH(SHIFT)) u_scale (
    .din  (p),
    .dout (scaled)
  );

  // Final halving of the accumulated total.
  trunc0_shift #(.IN_W(ACC_W), .OUT_W(ACC_W), .SH(1)) u_half (
    .din  (acc),
    .dout (half)
  );

  assign sat_hi = (half > Q_HI);
  assign sat_lo = (half < Q_LO);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (len_clamped == '0) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (last_pair) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: pair capture, product stage, accumulate, flush timer, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      p         <= '0;
      p_valid   <= 1'b0;
      flush     <= 2'd0;
      q_out     <= '0;
      sat       <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p         <= PW'(r_in) * PW'(a_in);
        remaining <= remaining - LEN_W'(1);
      end

      if (state == S_IDLE && start) begin
        acc       <= ACC_W'(q_in) + ACC_W'(q_in);
        remaining <= len_clamped;
      end else if (p_valid) begin
        acc <= acc + scaled;
      end

      if (state != S_DRAIN && state_nx == S_DRAIN) begin
        flush <= FLUSH_CY;
      end else if (flush != 2'd0) begin
        flush <= flush - 2'd1;
      end

      if (state == S_DRAIN && drain_done) begin
        sat <= sat_hi || sat_lo;
        if (sat_hi) begin
          q_out <= {1'b0, {(W-1){1'b1}}};
        end else if (sat_lo) begin
          q_out <= {1'b1, {(W-1){1'b0}}};
        end else begin
          q_out <= half[W-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_levinson_dot.sv
// ============================================================================
// Module   : tb_levinson_dot
// Purpose  : Self-checking bench for levinson_dot with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_levinson_dot;

  localparam longint QMAX = (longint'(1) <<< 31) - 1;
  localparam longint QMIN = -(longint'(1) <<< 31);

  logic               clk;
  logic               rst;
  logic               start;
  logic [4:0]         len;
  logic signed [31:0] q_in;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] r_in;
  logic signed [31:0] a_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] q_out;
  logic               sat;

  int total;
  int bad;

  typedef struct {
    logic signed [31:0] q;
    logic               s;
  } exp_t;

  exp_t               sb[$];
  logic signed [31:0] rv[0:31];
  logic signed [31:0] av[0:31];

  levinson_dot dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .q_in      (q_in),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .a_in      (a_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Divide by 2^sh rounding toward zero, via magnitude.
  function automatic longint tr0(input longint x, input int sh);
    longint m;
    if (x < 0) begin
      m = -x;
      return -(m >>> sh);
    end
    return x >>> sh;
  endfunction

  task automatic model(input int eff, input logic signed [31:0] qin,
                       output logic signed [31:0] eq, output logic es);
    longint acc;
    longint h;
    acc = 2 * longint'(qin);
    for (int i = 0; i < eff; i++) begin
      acc += tr0(longint'(rv[i]) * longint'(av[i]), 27);
    end
    h = tr0(acc, 1);
    es = 1'b0;
    if (h > QMAX) begin
      eq = 32'sh7fffffff;
      es = 1'b1;
    end else if (h < QMIN) begin
      eq = 32'sh80000000;
      es = 1'b1;
    end else begin
      eq = 32'(h);
    end
  endtask

  // Scoreboard: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("q_out", q_out, e.q);
        check("sat", sat, e.s);
      end
    end
  end

  task automatic do_update(input int n_len, input logic signed [31:0] qin,
                           input bit gappy, input int hold);
    int                 eff;
    int                 got;
    int                 cyc;
    int                 lat;
    bit                 acc_now;
    logic signed [31:0] eq;
    logic               es;
    exp_t               e;
    eff = (n_len > 16) ? 16 : n_len;
    model(eff, qin, eq, es);
    e.q = eq;
    e.s = es;
    sb.push_back(e);

    @(posedge clk); #1;
    start = 1'b1;
    len   = 5'(n_len);
    q_in  = qin;
    @(posedge clk); #1;
    start = gappy;          // extra starts while busy must be ignored
    len   = 5'd3;
    q_in  = 32'sd999;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", in_ready, (eff > 0) ? 1 : 0);

    got = 0;
    cyc = 0;
    while (got < eff && cyc < 400) begin
      in_valid = gappy ? (cyc % 2 == 0) : 1'b1;
      r_in     = rv[got];
      a_in     = av[got];
      @(negedge clk);
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) got++;
      cyc++;
    end
    in_valid = 1'b0;
    check("pairs_accepted", got, eff);
    check("in_ready_after_last", in_ready, 0);

    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 40) break;
      @(posedge clk);
      lat++;
    end
    check("latency", lat, 3);

    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_q_out", q_out, eq);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end

    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_handshake", busy, 0);
    check("valid_after_handshake", out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    q_in      = '0;
    in_valid  = 1'b0;
    r_in      = '0;
    a_in      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q_out", q_out, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;

    // Basic positive case: (10 + 4) / 2 = 7.
    rv[0] = 32'sh08000000; av[0] = 32'sd4;
    do_update(1, 32'sd5, 1'b0, 0);

    // Toward-zero rounding on both halving and product scaling.
    rv[0] = 32'sh08000000; av[0] = -32'sd1;
    do_update(1, -32'sd3, 1'b0, 0);
    rv[0] = -32'sd1; av[0] = 32'sd1;
    do_update(1, 32'sd0, 1'b0, 0);

    // Positive and negative saturation at full length.
    for (int i = 0; i < 16; i++) begin
      rv[i] = 32'sh7fffffff;
      av[i] = 32'sh7fffffff;
    end
    do_update(16, 32'sh7fffffff, 1'b0, 0);
    for (int i = 0; i < 16; i++) av[i] = 32'sh80000001;
    do_update(16, 32'sh7fffffff, 1'b0, 0);

    // Same data back-to-back, then with gaps, junk starts and a stalled output.
    for (int i = 0; i < 4; i++) begin
      rv[i] = $urandom;
      av[i] = $urandom;
    end
    do_update(4, 32'sd1234, 1'b0, 0);
    do_update(4, 32'sd1234, 1'b1, 5);

    // Zero length passes the seed straight through; oversize length clamps.
    do_update(0, -32'sd12345, 1'b0, 0);
    for (int i = 0; i < 32; i++) begin
      rv[i] = $urandom;
      av[i] = $urandom;
    end
    do_update(31, -32'sd777, 1'b0, 0);

    // A few random lengths and seeds.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) begin
        rv[i] = $urandom;
        av[i] = $urandom;
      end
      do_update(1 + int'($urandom_range(15)), $urandom, 1'b0, 1);
    end

    // Leave a known nonzero result in q_out, then reset mid-accumulation.
    rv[0] = 32'sh08000000; av[0] = 32'sd4;
    do_update(1, 32'sd5, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      rv[i] = $urandom;
      av[i] = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b1;
    len   = 5'd8;
    q_in  = 32'sd100;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    r_in     = rv[0];
    a_in     = av[0];
    @(posedge clk); #1;
    r_in = rv[1];
    a_in = av[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_mid_update", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q_out", q_out, 0);
    check("midrst_sat", sat, 0);

    rv[0] = 32'sh08000000; av[0] = 32'sd4;
    do_update(1, 32'sd5, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
